// File: rtl/hazard_pkg.sv
// Shared constants, forwarding-select encoding and register-match helper
// for the scalar/vector hazard unit.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 2 ** REG_AW;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Register 0 is hardwired, so it never matches anything.
    function automatic logic regMatch(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_sb_vsb_scoreboard.sv
// Vector scoreboard: one pending bit per vector register for in-flight
// multi-cycle ops, an outstanding counter and a sticky completion error.
module vsb_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = hazard_pkg::REG_AW,
    parameter int NREGS   = 2 ** REG_AW,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [REG_AW-1:0] issueReg,
    input  logic              done,
    input  logic [REG_AW-1:0] doneReg,
    output logic [NREGS-1:0]  pending,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              sb_err
);

    logic             setEn;
    logic             clrEn;
    logic [NREGS-1:0] pendingNext;
    logic [CNT_W-1:0] cntNext;

    assign setEn = issue && (issueReg != '0);
    assign clrEn = done && pending[doneReg];

    // Clear before set so a same-cycle reissue of the completing register
    // keeps the bit for the younger op.
    always_comb begin
        pendingNext = pending;
        if (clrEn) pendingNext[doneReg] = 1'b0;
        if (setEn) pendingNext[issueReg] = 1'b1;
        cntNext = out_cnt + CNT_W'(setEn) - CNT_W'(clrEn);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            out_cnt <= '0;
            sb_err  <= 1'b0;
        end else begin
            if (setEn && !clrEn)
                assert (int'(out_cnt) < MAX_OUT) else $error("scoreboard counter overflow");
            if (clrEn && !setEn)
                assert (out_cnt != '0) else $error("scoreboard counter underflow");
            pending <= pendingNext;
            out_cnt <= cntNext;
            if (done && !clrEn) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit for the five-stage scalar/vector pipeline: forwarding selects,
// scalar stalls and scoreboard-based stalls for multi-cycle vector ops.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int REG_AW  = hazard_pkg::REG_AW,
    parameter int NREGS   = 2 ** REG_AW,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] writeregD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              VregwriteM,
    input  logic              VregwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              busy,
    input  logic [1:0]        branchD,
    input  logic              vuseD,
    input  logic              mcD,
    input  logic              mcE,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_wreg,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        VforwardaE,
    output logic [1:0]        VforwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushE,
    output logic [NREGS-1:0]  pending,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              sb_err
);

    logic lwStall, brStall, rawStall, wawStall, fullStall, issue;

    function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] src,
                                        input logic weM, input logic weW);
        if (weM && regMatch(src, writeregM)) return FWD_M;
        if (weW && regMatch(src, writeregW)) return FWD_W;
        return FWD_RF;
    endfunction

    assign forwardaD  = regwriteM && regMatch(rsD, writeregM);
    assign forwardbD  = regwriteM && regMatch(rtD, writeregM);
    assign forwardaE  = fwdSel(rsE, regwriteM, regwriteW);
    assign forwardbE  = fwdSel(rtE, regwriteM, regwriteW);
    assign VforwardaE = fwdSel(rsE, VregwriteM, VregwriteW);
    assign VforwardbE = fwdSel(rtE, VregwriteM, VregwriteW);

    assign lwStall = memtoregE && ((rtE == rsD) || (rtE == rtD));
    assign brStall = (branchD != 2'b00) &&
                     ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                      (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

    // Scoreboard stalls cover both recorded ops and the one issuing from E now.
    assign rawStall  = !reset && vuseD &&
                       (pending[rsD] || pending[rtD] ||
                        (mcE && (regMatch(rsD, writeregE) || regMatch(rtD, writeregE))));
    assign wawStall  = !reset && mcD && (writeregD != '0) &&
                       (pending[writeregD] || (mcE && (writeregE == writeregD)));
    assign fullStall = !reset && mcD && ((int'(out_cnt) + int'(mcE)) >= MAX_OUT);

    assign stallD = lwStall || brStall || rawStall || wawStall || fullStall || busy;
    assign stallF = stallD;
    assign flushE = stallD;
    assign stallE = busy;
    assign stallM = busy;
    assign issue  = mcE && !stallE && !reset;

    vsb_scoreboard #(
        .REG_AW (REG_AW),
        .NREGS  (NREGS),
        .MAX_OUT(MAX_OUT),
        .CNT_W  (CNT_W)
    ) uScoreboard (
        .clk     (clk),
        .reset   (reset),
        .issue   (issue),
        .issueReg(writeregE),
        .done    (mc_done),
        .doneReg (mc_wreg),
        .pending (pending),
        .out_cnt (out_cnt),
        .sb_err  (sb_err)
    );

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: forwarding, scalar stalls, scoreboard
// issue/complete, full queue, completion errors and asynchronous reset.
module tb_hazard_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW, mc_wreg;
    logic        regwriteE, regwriteM, regwriteW, VregwriteM, VregwriteW;
    logic        memtoregE, memtoregM, busy, vuseD, mcD, mcE, mc_done;
    logic [1:0]  branchD;
    logic        forwardaD, forwardbD, stallF, stallD, stallE, stallM, flushE, sb_err;
    logic [1:0]  forwardaE, forwardbE, VforwardaE, VforwardbE;
    logic [31:0] pending;
    logic [2:0]  out_cnt;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    hazard_sb dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .VregwriteM(VregwriteM), .VregwriteW(VregwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .busy(busy),
        .branchD(branchD), .vuseD(vuseD), .mcD(mcD), .mcE(mcE),
        .mc_done(mc_done), .mc_wreg(mc_wreg),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .VforwardaE(VforwardaE), .VforwardbE(VforwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .pending(pending), .out_cnt(out_cnt), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearIns();
        {rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW, mc_wreg} = '0;
        {regwriteE, regwriteM, regwriteW, VregwriteM, VregwriteW} = '0;
        {memtoregE, memtoregM, busy, vuseD, mcD, mcE, mc_done} = '0;
        branchD = 2'b00;
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueTo(input logic [4:0] r);
        mcE = 1'b1; writeregE = r;
        tick();
        mcE = 1'b0; writeregE = '0;
    endtask

    task automatic doneOn(input logic [4:0] r);
        mc_done = 1'b1; mc_wreg = r;
        tick();
        mc_done = 1'b0; mc_wreg = '0;
    endtask

    initial begin
        clearIns();
        reset = 1'b1;
        #1;
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_cnt", 64'(out_cnt), 64'd0);
        chk("reset_err", 64'(sb_err), 64'd0);
        chk("reset_stallD", 64'(stallD), 64'd0);
        tick();
        reset = 1'b0;
        #1;

        // Forwarding priority and zero-register guard
        rsE = 5'd5; writeregM = 5'd5; writeregW = 5'd5; regwriteM = 1'b1; regwriteW = 1'b1;
        #1 chk("fwdaE_M", 64'(forwardaE), 64'd2);
        chk("VfwdaE_none", 64'(VforwardaE), 64'd0);
        regwriteM = 1'b0;
        #1 chk("fwdaE_W", 64'(forwardaE), 64'd1);
        VregwriteM = 1'b1; rtE = 5'd5;
        #1 chk("VfwdbE_M", 64'(VforwardbE), 64'd2);
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        #1 chk("fwdaE_zero", 64'(forwardaE), 64'd0);
        clearIns();
        rsD = 5'd9; writeregM = 5'd9; regwriteM = 1'b1;
        #1 chk("fwdaD", 64'(forwardaD), 64'd1);
        chk("fwdbD", 64'(forwardbD), 64'd0);
        branchD = 2'b01; memtoregM = 1'b1;
        #1 chk("brstall", 64'(stallD), 64'd1);
        clearIns();

        // Multi-cycle RAW against issuing and pending op
        mcE = 1'b1; writeregE = 5'd7; vuseD = 1'b1; rsD = 5'd7;
        #1 chk("raw_issue_stall", 64'(stallD), 64'd1);
        tick();
        mcE = 1'b0; writeregE = '0;
        #1 chk("raw_pend_stall", 64'(stallD), 64'd1);
        chk("raw_pend_bit", 64'(pending), 64'h80);
        chk("raw_cnt1", 64'(out_cnt), 64'd1);
        mc_done = 1'b1; mc_wreg = 5'd7;
        #1 chk("raw_done_cycle_stall", 64'(stallD), 64'd1);
        tick();
        mc_done = 1'b0;
        #1 chk("raw_release", 64'(stallD), 64'd0);
        chk("raw_cnt0", 64'(out_cnt), 64'd0);
        clearIns();

        // Full queue
        issueTo(5'd1); issueTo(5'd2); issueTo(5'd3); issueTo(5'd4);
        chk("full_cnt4", 64'(out_cnt), 64'd4);
        chk("full_pending", 64'(pending), 64'h1E);
        mcD = 1'b1; writeregD = 5'd9;
        #1 chk("full_stall", 64'(stallD), 64'd1);
        mc_done = 1'b1; mc_wreg = 5'd2;
        #1 chk("full_done_cycle", 64'(stallD), 64'd1);
        tick();
        mc_done = 1'b0;
        #1 chk("full_release", 64'(stallD), 64'd0);
        chk("full_cnt3", 64'(out_cnt), 64'd3);
        writeregD = 5'd3;
        #1 chk("waw_stall", 64'(stallD), 64'd1);
        mcD = 1'b0; writeregD = '0;
        doneOn(5'd1); doneOn(5'd3); doneOn(5'd4);
        chk("drain_cnt", 64'(out_cnt), 64'd0);
        chk("drain_err", 64'(sb_err), 64'd0);

        // Same-cycle issue and done on the same register
        issueTo(5'd3);
        mcE = 1'b1; writeregE = 5'd3; mc_done = 1'b1; mc_wreg = 5'd3;
        tick();
        clearIns();
        chk("same_pending", 64'(pending), 64'h8);
        chk("same_cnt", 64'(out_cnt), 64'd1);
        doneOn(5'd3);
        chk("same_drain", 64'(out_cnt), 64'd0);

        // Completion error then asynchronous reset mid-cycle
        doneOn(5'd12);
        chk("err_set", 64'(sb_err), 64'd1);
        chk("err_cnt", 64'(out_cnt), 64'd0);
        issueTo(5'd5); issueTo(5'd6);
        chk("pre_reset_cnt", 64'(out_cnt), 64'd2);
        #2 reset = 1'b1;
        mcE = 1'b1; writeregE = 5'd8; vuseD = 1'b1; rsD = 5'd8;
        #1 chk("async_pending", 64'(pending), 64'd0);
        chk("async_cnt", 64'(out_cnt), 64'd0);
        chk("async_err", 64'(sb_err), 64'd0);
        chk("reset_raw_forced", 64'(stallD), 64'd0);
        tick();
        chk("reset_no_issue", 64'(out_cnt), 64'd0);
        #2 reset = 1'b0;
        clearIns();
        tick();

        // Busy blocks issue; load-use stall
        busy = 1'b1; mcE = 1'b1; writeregE = 5'd8;
        #1 chk("busy_stallE", 64'(stallE), 64'd1);
        chk("busy_stallM", 64'(stallM), 64'd1);
        chk("busy_stallD", 64'(stallD), 64'd1);
        tick();
        chk("busy_no_issue", 64'(out_cnt), 64'd0);
        clearIns();
        memtoregE = 1'b1; rtE = 5'd4; rsD = 5'd4;
        #1 chk("lw_stallD", 64'(stallD), 64'd1);
        chk("lw_flushE", 64'(flushE), 64'd1);
        chk("lw_stallF", 64'(stallF), 64'd1);
        chk("lw_stallE", 64'(stallE), 64'd0);
        clearIns();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
